// File: rtl/display_pkg.sv
// Shared seven-segment constants for the digit scan driver.
// Patterns are active-high, bit 0 = segment a ... bit 6 = segment g.
package display_pkg;

  // Hex 0-F, entry [n] is the glyph for nibble n (A b C d E F for 10-15)
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_DP  = 8'h80;

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-high seven-segment pattern (g..a).
// Latency: combinational; no flow control.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/digit_scan_driver.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow update and leading-zero blanking.
// Latency: an/seg registered, one clk after idx/cnt/display; no backpressure, load is a fire-and-forget pulse.
module digit_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL       = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;

  logic [IDX_W-1:0]        msd;
  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    blank_digit;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              seg_nxt;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      if (tick)
        idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // The display register only moves at a frame wrap so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp;
      end else if (pend_valid) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp;
      pend_valid <= 1'b1;
    end
  end

  always_comb begin
    msd    = '0;
    nib    = 4'h0;
    dp_bit = 1'b0;
    an_nxt = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_val[4*i +: 4] != 4'h0)
        msd = IDX_W'(i);
      if (idx == IDX_W'(i)) begin
        nib       = disp_val[4*i +: 4];
        dp_bit    = disp_dp[i];
        an_nxt[i] = (cnt >= BLANK_LIM);
      end
    end
  end

  seg_decoder u_dec (
    .hex (nib),
    .seg (dec)
  );

  // Digit 0 can never exceed msd, so it is never blanked.
  assign blank_digit = blank_en && (idx > msd);
  assign seg_nxt     = (blank_digit ? SEG_OFF : {1'b0, dec}) | (dp_bit ? SEG_DP : SEG_OFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {NUM_DIGITS{POL}};
      seg <= {8{POL}};
    end else begin
      an  <= an_nxt ^ {NUM_DIGITS{POL}};
      seg <= seg_nxt ^ {8{POL}};
    end
  end

endmodule
